// File: rtl/cpu_run_controller.sv
// Run/halt/step sequencer with PC breakpoint and halted register-dump streaming.
// Execution is gated through the per-cycle clock enable cpu_en.
module cpu_run_controller #(
  parameter bit          RUN_ON_RESET = 1'b0,
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned NUM_REGS     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              bp_enable,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       fetch_pc,
  output logic              cpu_en,
  output logic [3:0]        debug_reg_select,
  input  logic [31:0]       debug_reg_in,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic [3:0]        dump_index,
  output logic              dump_last,
  output logic              halted,
  output logic              bp_hit,
  output logic              step_done
);

  typedef enum logic [2:0] {StHalt, StRun, StStep, StDumpSel, StDumpOut} state_e;

  localparam logic [1:0] OpRun  = 2'b00;
  localparam logic [1:0] OpHalt = 2'b01;
  localparam logic [1:0] OpStep = 2'b10;
  localparam logic [1:0] OpDump = 2'b11;

  localparam state_e      ResetState = RUN_ON_RESET ? StRun : StHalt;
  localparam logic [3:0]  LastIdx    = 4'(NUM_REGS - 1);

  state_e              stateQ, stateD;
  logic [STEP_W-1:0]   stepCntQ, stepCntD;
  logic [3:0]          idxQ, idxD;
  logic                skipQ, skipD;
  logic                dumpValidQ, dumpValidD;
  logic [31:0]         dumpDataQ, dumpDataD;
  logic [3:0]          dumpIndexQ, dumpIndexD;
  logic                dumpLastQ, dumpLastD;
  logic                bpHitQ, bpHitD;
  logic                stepDoneQ, stepDoneD;

  logic cmdAccept;
  logic haltCmd;
  logic bpMatch;
  logic bpStop;
  logic execState;

  assign execState = (stateQ == StRun) || (stateQ == StStep);
  assign cmd_ready = execState || (stateQ == StHalt);
  assign cmdAccept = cmd_valid && cmd_ready;
  assign haltCmd   = cmdAccept && (cmd_op == OpHalt);
  assign bpMatch   = bp_enable && (fetch_pc == bp_addr);
  // skip lets the instruction sitting at the breakpoint PC run once after resume
  assign bpStop    = bpMatch && !skipQ;
  assign cpu_en    = execState && !bpStop && !haltCmd;

  assign halted           = (stateQ == StHalt);
  assign debug_reg_select = idxQ;
  assign dump_valid       = dumpValidQ;
  assign dump_data        = dumpDataQ;
  assign dump_index       = dumpIndexQ;
  assign dump_last        = dumpLastQ;
  assign bp_hit           = bpHitQ;
  assign step_done        = stepDoneQ;

  always_comb begin
    stateD     = stateQ;
    stepCntD   = stepCntQ;
    idxD       = idxQ;
    skipD      = skipQ;
    dumpValidD = dumpValidQ;
    dumpDataD  = dumpDataQ;
    dumpIndexD = dumpIndexQ;
    dumpLastD  = dumpLastQ;
    bpHitD     = 1'b0;
    stepDoneD  = 1'b0;

    unique case (stateQ)
      StHalt: begin
        if (cmdAccept) begin
          case (cmd_op)
            OpRun: begin
              stateD = StRun;
              skipD  = 1'b1;
            end
            OpStep: begin
              stateD   = StStep;
              stepCntD = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
              skipD    = 1'b1;
            end
            OpDump: begin
              stateD = StDumpSel;
              idxD   = 4'd0;
            end
            default: ;
          endcase
        end
      end
      StRun, StStep: begin
        if (haltCmd) begin
          stateD = StHalt;
        end else if (bpStop) begin
          stateD = StHalt;
          bpHitD = 1'b1;
        end else begin
          // cpu_en is high on this path
          skipD = 1'b0;
          if (stateQ == StStep) begin
            stepCntD = stepCntQ - STEP_W'(1);
            if (stepCntQ == STEP_W'(1)) begin
              stateD    = StHalt;
              stepDoneD = 1'b1;
            end
          end
        end
      end
      StDumpSel: begin
        dumpDataD  = debug_reg_in;
        dumpIndexD = idxQ;
        dumpLastD  = (idxQ == LastIdx);
        dumpValidD = 1'b1;
        stateD     = StDumpOut;
      end
      StDumpOut: begin
        if (dump_ready) begin
          dumpValidD = 1'b0;
          if (dumpLastQ) begin
            stateD = StHalt;
          end else begin
            idxD   = idxQ + 4'd1;
            stateD = StDumpSel;
          end
        end
      end
      default: stateD = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ     <= ResetState;
      stepCntQ   <= '0;
      idxQ       <= 4'd0;
      skipQ      <= 1'b0;
      dumpValidQ <= 1'b0;
      dumpDataQ  <= 32'd0;
      dumpIndexQ <= 4'd0;
      dumpLastQ  <= 1'b0;
      bpHitQ     <= 1'b0;
      stepDoneQ  <= 1'b0;
    end else begin
      stateQ     <= stateD;
      stepCntQ   <= stepCntD;
      idxQ       <= idxD;
      skipQ      <= skipD;
      dumpValidQ <= dumpValidD;
      dumpDataQ  <= dumpDataD;
      dumpIndexQ <= dumpIndexD;
      dumpLastQ  <= dumpLastD;
      bpHitQ     <= bpHitD;
      stepDoneQ  <= stepDoneD;
    end
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Run/halt/step sequencer for the single-cycle computer. Gates execution through a per-cycle clock enable (cpu_en).
- Stops on a PC breakpoint.
- When halted, walks debug_reg_select over the register file and streams each register value out on a valid/ready channel.
- Sits between a host command interface (UART/JTAG bridge) and the computer top level.

Parameters:
- RUN_ON_RESET, 0, 1 = leave reset in RUN, 0 = leave reset in HALT
- STEP_W, 16, width of step count argument
- NUM_REGS, 16, registers dumped (indices 0..NUM_REGS-1; must be ≤16)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller accepts command this cycle
- cmd_op  in  2  00 RUN, 01 HALT, 10 STEP, 11 DUMP
- cmd_arg  in  STEP_W  step count for STEP
- bp_enable  in  1  breakpoint armed
- bp_addr  in  32  breakpoint PC
- fetch_pc  in  32  current PC from computer
- cpu_en  out  1  computer advances one instruction on this clk edge when 1
- debug_reg_select  out  4  register index driven to computer
- debug_reg_in  in  32  combinational register read from computer
- dump_valid  out  1  dump word valid
- dump_ready  in  1  sink accepts dump word
- dump_data  out  32  captured register value
- dump_index  out  4  index of dump_data
- dump_last  out  1  dump_data is last register
- halted  out  1  state == HALT
- bp_hit  out  1  one-cycle pulse: breakpoint stopped execution
- step_done  out  1  one-cycle pulse: step count exhausted

Behaviour:
- States: HALT, RUN, STEP, DUMP_SEL, DUMP_OUT.
- Reset (async, reset==0):
  - state = RUN if RUN_ON_RESET else HALT.
  - step_cnt = 0; idx = 0; skip = 0.
  - dump_valid = 0, dump_data = 0, dump_index = 0, dump_last = 0, debug_reg_select = 0.
  - bp_hit = 0, step_done = 0.
- Reset mid-dump or mid-step discards all progress.
- cmd_ready = 1 in HALT, RUN, STEP; 0 in DUMP_SEL, DUMP_OUT. Command accepted on cmd_valid && cmd_ready.
- HALT:
  - RUN → RUN, skip = 1.
  - STEP → STEP, step_cnt = (cmd_arg==0 ? 1 : cmd_arg), skip = 1.
  - DUMP → DUMP_SEL, idx = 0.
  - HALT → no-op.
- RUN/STEP: only HALT has effect (→ HALT next cycle, no pulse). Other ops are accepted and ignored.
- bp_match = bp_enable && fetch_pc == bp_addr.
- cpu_en (combinational) = (state==RUN || state==STEP) && !(bp_match && !skip) && !(accepted HALT this cycle).
- skip clears on the first cycle cpu_en==1. It lets execution resume from a breakpoint PC.
- Breakpoint: in RUN/STEP with bp_match && !skip → cpu_en = 0 that cycle, → HALT, bp_hit pulses next cycle. The instruction at bp_addr is not executed.
- STEP:
  - Each cpu_en cycle decrements step_cnt.
  - When step_cnt==1 && cpu_en → HALT, step_done pulses next cycle.
  - Exactly N instructions execute.
  - Breakpoint before exhaustion wins: bp_hit only, no step_done.
- DUMP_SEL: debug_reg_select = idx (registered, stable all cycle). At clock edge capture dump_data = debug_reg_in, dump_index = idx, dump_last = (idx == NUM_REGS-1), dump_valid = 1 → DUMP_OUT.
- DUMP_OUT:
  - Hold dump_data, dump_index, dump_last and dump_valid stable until dump_ready.
  - On handshake: dump_valid = 0; if dump_last → HALT, else idx+1 → DUMP_SEL.
  - Minimum 2 cycles per register, so 2*NUM_REGS cycles for a full dump with dump_ready tied high.
- cpu_en = 0 throughout HALT/DUMP; computer state is frozen during the dump.
- halted is combinational from state.

Test Plan:
- Reset release with RUN_ON_RESET=0, cmd RUN, bp_enable=0 → cpu_en=1 every cycle from the cycle after accept; cmd HALT → cpu_en=0 in the accept cycle, halted=1 next cycle.
- bp_enable=1, bp_addr=0x10, program sequential from 0 → cpu_en deasserts with fetch_pc=0x10, bp_hit one pulse, halted=1. Cmd RUN → fetch_pc advances to 0x14 (skip works); no re-hit.
- Cmd STEP arg=3 from PC 0x0 → exactly 3 cpu_en cycles, fetch_pc=0xC, step_done one pulse. STEP arg=0 → exactly 1 instruction.
- STEP arg=10 with bp at 0x8 from PC 0 → 2 instructions, halt at 0x8, bp_hit=1, step_done never asserted.
- Halted with regs Rn=n*0x11111111, cmd DUMP, dump_ready=1 → 16 words, indices 0..15, data match, dump_last only on index 15, 32 cycles, then halted=1. Repeat with dump_ready toggling randomly → dump_data/dump_index held stable while valid && !ready.
- Assert reset=0 mid-dump (idx=7) and mid-step (step_cnt=5) → all outputs at reset values immediately (async); after release halted=1, cpu_en=0, dump_valid=0.
